pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_slot.sv | 32 +++
 rtl/pipe_stage_reg.sv | 135 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register slice.
// The state encoding doubles as the held-entry count.
package pipe_pkg;

  localparam int DROP_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  // Saturating add of a 0-2 entry count onto the drop counter.
  function automatic logic [DROP_CNT_W-1:0] sat_add(input logic [DROP_CNT_W-1:0] a,
                                                    input logic [1:0]            b);
    logic [DROP_CNT_W:0] sum;
    sum = {1'b0, a} + {{(DROP_CNT_W-1){1'b0}}, b};
    return sum[DROP_CNT_W] ? '1 : sum[DROP_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One valid+ctrl+data holding register; clear (or reset) returns it to a bubble.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int              DATA_W      = 32,
  parameter int              CTRL_W      = 16,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              q_valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  always_ff @(posedge clk) begin
    if (Reset || clear) begin
      q_valid <= 1'b0;
      q_ctrl  <= CTRL_BUBBLE;
      q_data  <= '0;
    end else if (load) begin
      q_valid <= 1'b1;
      q_ctrl  <= d_ctrl;
      q_data  <= d_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage with optional skid entry, hold, flush and drop counter.
// Outputs come straight from the main slot flops.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                CTRL_W      = 16,
  parameter int                SKID_EN     = 1,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_W-1:0]     in_ctrl,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [DATA_W-1:0]     out_data,
  input  logic                  hold,
  input  logic                  flush,
  output logic [1:0]            occupancy,
  output logic [DROP_CNT_W-1:0] drop_count
);

  pipe_state_e           state_q, state_d;
  logic                  rdy_q;
  logic                  push, pop;
  logic                  main_load, main_clear, main_from_skid;
  logic                  skid_load, skid_clear;
  logic                  skid_valid;
  logic [CTRL_W-1:0]     skid_ctrl, main_d_ctrl;
  logic [DATA_W-1:0]     skid_data, main_d_data;
  logic [DROP_CNT_W-1:0] drop_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready && !hold;

  generate
    if (SKID_EN != 0) begin : g_skid
      assign in_ready = rdy_q && !Reset;
    end else begin : g_noskid
      assign in_ready = (!out_valid || (out_ready && !hold)) && !Reset;
    end
  endgenerate

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_d    = ST_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: if (push) begin
          state_d   = ST_ONE;
          main_load = 1'b1;
        end
        ST_ONE: begin
          if (push && pop) begin
            main_load = 1'b1;
          end else if (push) begin
            state_d   = ST_TWO;
            skid_load = 1'b1;
          end else if (pop) begin
            state_d    = ST_EMPTY;
            main_clear = 1'b1;
          end
        end
        ST_TWO: if (pop) begin
          state_d        = ST_ONE;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_clear     = 1'b1;
        end
        default: begin
          state_d    = ST_EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_d_data = main_from_skid ? skid_data : in_data;

  // Registered ready: only the transition into TWO closes the input.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= ST_EMPTY;
      rdy_q   <= 1'b1;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != ST_TWO);
      if (flush) drop_q <= sat_add(drop_q, occupancy);
    end
  end

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_BUBBLE(CTRL_BUBBLE)) u_main (
    .clk     (clk),
    .Reset   (Reset),
    .load    (main_load),
    .clear   (main_clear),
    .d_ctrl  (main_d_ctrl),
    .d_data  (main_d_data),
    .q_valid (out_valid),
    .q_ctrl  (out_ctrl),
    .q_data  (out_data)
  );

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_BUBBLE(CTRL_BUBBLE)) u_skid (
    .clk     (clk),
    .Reset   (Reset),
    .load    (skid_load),
    .clear   (skid_clear),
    .d_ctrl  (in_ctrl),
    .d_data  (in_data),
    .q_valid (skid_valid),
    .q_ctrl  (skid_ctrl),
    .q_data  (skid_data)
  );

  // Slot valid flops give the count directly: skid is only ever full behind main.
  assign occupancy  = {skid_valid, out_valid && !skid_valid};
  assign drop_count = drop_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: skid-mode instance for streaming/backpressure/flush/hold/saturation,
// plus a single-entry instance for the combinational-ready behaviour.
module tb_pipe_stage_reg;

  localparam logic [15:0] BUB = 16'h00F0;

  logic        clk = 1'b0;
  logic        Reset;
  int          vectors = 0;
  int          miscompares = 0;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_hold, s_flush;
  logic [15:0] s_in_ctrl, s_out_ctrl;
  logic [31:0] s_in_data, s_out_data;
  logic [1:0]  s_occ;
  logic [7:0]  s_drop;

  logic        z_in_valid, z_in_ready, z_out_valid, z_out_ready, z_hold, z_flush;
  logic [15:0] z_in_ctrl, z_out_ctrl;
  logic [31:0] z_in_data, z_out_data;
  logic [1:0]  z_occ;
  logic [7:0]  z_drop;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID_EN(1), .CTRL_BUBBLE(BUB)) dut (
    .clk(clk), .Reset(Reset),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_ctrl(s_in_ctrl), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
    .hold(s_hold), .flush(s_flush), .occupancy(s_occ), .drop_count(s_drop)
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID_EN(0), .CTRL_BUBBLE(16'h0000)) dut0 (
    .clk(clk), .Reset(Reset),
    .in_valid(z_in_valid), .in_ready(z_in_ready), .in_ctrl(z_in_ctrl), .in_data(z_in_data),
    .out_valid(z_out_valid), .out_ready(z_out_ready), .out_ctrl(z_out_ctrl), .out_data(z_out_data),
    .hold(z_hold), .flush(z_flush), .occupancy(z_occ), .drop_count(z_drop)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_s(input logic [31:0] d);
    s_in_valid = 1'b1;
    s_in_data  = d;
    s_in_ctrl  = d[15:0];
  endtask

  initial begin
    Reset = 1'b1;
    s_in_valid = 0; s_in_ctrl = 0; s_in_data = 0; s_out_ready = 0; s_hold = 0; s_flush = 0;
    z_in_valid = 0; z_in_ctrl = 0; z_in_data = 0; z_out_ready = 0; z_hold = 0; z_flush = 0;

    // reset state
    tick();
    chk("rst_in_ready", s_in_ready, 0);
    chk("rst_out_valid", s_out_valid, 0);
    chk("rst_out_ctrl", s_out_ctrl, BUB);
    chk("rst_out_data", s_out_data, 0);
    chk("rst_occ", s_occ, 0);
    chk("rst_drop", s_drop, 0);
    Reset = 1'b0;
    #1;
    chk("post_rst_in_ready", s_in_ready, 1);
    chk("post_rst_z_in_ready", z_in_ready, 1);

    // stream 0x11, 0x22, 0x33
    s_out_ready = 1'b1;
    push_s(32'h11); tick();
    chk("stream_d0", s_out_data, 32'h11);
    chk("stream_rdy0", s_in_ready, 1);
    push_s(32'h22); tick();
    chk("stream_d1", s_out_data, 32'h22);
    chk("stream_c1", s_out_ctrl, 16'h22);
    chk("stream_rdy1", s_in_ready, 1);
    push_s(32'h33); tick();
    chk("stream_d2", s_out_data, 32'h33);
    chk("stream_rdy2", s_in_ready, 1);
    s_in_valid = 1'b0; tick();
    chk("stream_drain_valid", s_out_valid, 0);
    chk("stream_drain_data", s_out_data, 0);
    chk("stream_drain_ctrl", s_out_ctrl, BUB);

    // backpressure 0xA0, 0xA1
    s_out_ready = 1'b0;
    push_s(32'hA0); tick();
    chk("bp_occ1", s_occ, 1);
    push_s(32'hA1); tick();
    chk("bp_occ2", s_occ, 2);
    chk("bp_rdy0", s_in_ready, 0);
    chk("bp_head", s_out_data, 32'hA0);
    s_in_valid = 1'b0; s_out_ready = 1'b1; tick();
    chk("bp_pop1", s_out_data, 32'hA1);
    chk("bp_occ_after_pop", s_occ, 1);
    chk("bp_rdy1", s_in_ready, 1);
    tick();
    chk("bp_empty", s_out_valid, 0);

    // flush with two held and a concurrent push
    s_out_ready = 1'b0;
    push_s(32'hB0); tick();
    push_s(32'hB1); tick();
    chk("fl_occ2", s_occ, 2);
    s_flush = 1'b1; push_s(32'hCC); tick();
    chk("fl_valid", s_out_valid, 0);
    chk("fl_ctrl", s_out_ctrl, BUB);
    chk("fl_occ", s_occ, 0);
    chk("fl_drop", s_drop, 2);
    s_flush = 1'b0; s_in_valid = 1'b0; tick();
    chk("fl_no_ghost", s_out_valid, 0);
    // flush with one held; the push into free space is discarded too
    push_s(32'hD0); tick();
    s_flush = 1'b1; push_s(32'hD1); tick();
    chk("fl1_occ", s_occ, 0);
    chk("fl1_valid", s_out_valid, 0);
    chk("fl1_drop", s_drop, 3);
    s_flush = 1'b0; s_in_valid = 1'b0;

    // hold with 0x55 presented, push into the free skid slot during hold
    push_s(32'h55); tick();
    s_hold = 1'b1; s_out_ready = 1'b1; push_s(32'h56); tick();
    chk("hold_d0", s_out_data, 32'h55);
    chk("hold_occ", s_occ, 2);
    s_in_valid = 1'b0; tick();
    chk("hold_d1", s_out_data, 32'h55);
    tick();
    chk("hold_d2", s_out_data, 32'h55);
    chk("hold_valid", s_out_valid, 1);
    s_hold = 1'b0; tick();
    chk("hold_release", s_out_data, 32'h56);
    chk("hold_release_occ", s_occ, 1);
    tick();
    chk("hold_empty", s_occ, 0);

    // drop counter saturation: 130 flushes of two entries, starting from 3
    s_out_ready = 1'b0;
    for (int i = 0; i < 130; i++) begin
      push_s(32'h100 + i); tick(); tick();
      s_in_valid = 1'b0; s_flush = 1'b1; tick();
      s_flush = 1'b0;
      if (i == 0) chk("sat_first", s_drop, 5);
    end
    chk("sat_255", s_drop, 255);

    // mid-operation reset together with flush: entries discarded, not counted
    push_s(32'hEE); tick();
    s_in_valid = 1'b0;
    Reset = 1'b1; s_flush = 1'b1; tick();
    chk("rst2_drop", s_drop, 0);
    chk("rst2_occ", s_occ, 0);
    chk("rst2_valid", s_out_valid, 0);
    chk("rst2_rdy", s_in_ready, 0);
    Reset = 1'b0; s_flush = 1'b0; #1;
    chk("rst2_rdy_after", s_in_ready, 1);
    tick();
    chk("rst2_drop_after", s_drop, 0);

    // single-entry variant: combinational ready
    z_out_ready = 1'b0; z_in_valid = 1'b1; z_in_data = 32'h77; tick();
    z_in_data = 32'h78; #1;
    chk("z_rdy_bp", z_in_ready, 0);
    tick();
    chk("z_no_push", z_out_data, 32'h77);
    chk("z_occ_a", z_occ, 1);
    z_out_ready = 1'b1; #1;
    chk("z_rdy_flow", z_in_ready, 1);
    tick();
    chk("z_pushpop", z_out_data, 32'h78);
    chk("z_occ_b", z_occ, 1);
    z_in_data = 32'h79; tick();
    chk("z_pushpop2", z_out_data, 32'h79);
    z_hold = 1'b1; #1;
    chk("z_rdy_hold", z_in_ready, 0);
    tick();
    chk("z_hold_stable", z_out_data, 32'h79);
    z_hold = 1'b0; z_in_valid = 1'b0; tick();
    chk("z_empty", z_occ, 0);
    chk("z_empty_valid", z_out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
